commit_ctrl: RTL and testbench
==============================

Name: commit_ctrl

Overview:
- In-order retirement sequencer between the ROB head and the architectural state: Regfile write port, LSB store-commit port and PC redirect.
- Retires one ready ROB entry at a time and drives the Regfile commit bundle (en/instr_id/rd/rob_pos/res) as registered 1-cycle pulses.
- Holds stores until the LSB acknowledges them.
- Turns a mispredicted branch into a one-cycle global flush (clear_branch + redirect); latches halt.

Parameters:
- ROB_IDX_W, 4, ROB position width; position 0 means "no tag".
- INSTR_ID_W, 6, instruction-id width.
- WORD_W, 32, data/PC width.

Ports:
- clk_in  in  1  clock
- rst_n_in  in  1  reset, asynchronous, active-low
- rdy_in  in  1  global ready; low freezes all state and outputs
- rob_head_valid_in  in  1  ROB non-empty
- rob_head_ready_in  in  1  head result available
- rob_head_pos_in  in  ROB_IDX_W  head position
- rob_head_instr_id_in  in  INSTR_ID_W  head instruction id
- rob_head_has_rd_in  in  1  head writes rd
- rob_head_rd_in  in  5  destination register
- rob_head_res_in  in  WORD_W  result value
- rob_head_is_store_in  in  1  head is a store
- rob_head_mispred_in  in  1  head branch mispredicted
- rob_head_target_in  in  WORD_W  correct PC for a mispredict
- rob_head_is_halt_in  in  1  head is the halt marker
- lsb_store_done_in  in  1  LSB finished the committed store
- lsb_store_pos_in  in  ROB_IDX_W  position of the finished store
- rob_pop_out  out  1  retire head (pulse)
- commit_to_regfile_en_out  out  1  Regfile write pulse
- commit_to_regfile_instr_id_out  out  INSTR_ID_W  instruction id for the write
- commit_to_regfile_rd_out  out  5  destination register
- commit_to_regfile_rob_pos_out  out  ROB_IDX_W  retiring ROB position
- commit_to_regfile_res_out  out  WORD_W  write data
- commit_to_lsb_en_out  out  1  store release pulse
- commit_to_lsb_rob_pos_out  out  ROB_IDX_W  position of the released store
- clear_branch_out  out  1  global flush pulse
- redirect_en_out  out  1  PC redirect pulse
- redirect_pc_out  out  WORD_W  redirect target
- halt_out  out  1  sticky halt
- commit_cnt_out  out  32  retired-instruction count

Behaviour:
- All outputs are registered; reset value is 0 for every output; state resets to IDLE.
- Reset is asynchronous and wins over any state, including mid-WAIT_STORE and FLUSH.
- rdy_in=0: no state, output or counter changes; pulses hold their value until the first rdy_in=1 edge, then clear.
- FSM states: IDLE, WAIT_STORE, FLUSH, HALTED.
- Head evaluation is suppressed in any cycle where rob_pop_out=1 (ROB head not yet advanced), so the peak rate is 1 retire per 2 cycles.
- IDLE, valid&ready, priority:
  - is_halt: rob_pop pulse; then HALTED.
  - is_store: commit_to_lsb_en pulse with pos; then WAIT_STORE; no pop yet.
  - mispred: rob_pop pulse; Regfile write if has_rd; latch target; then FLUSH.
  - otherwise: rob_pop pulse; Regfile write pulse if has_rd (bundle = head fields); stay IDLE.
- WAIT_STORE: on lsb_store_done_in with lsb_store_pos_in == latched pos, rob_pop pulse and return to IDLE; a done with a non-matching pos is ignored.
- FLUSH: exactly one cycle with clear_branch_out=1, redirect_en_out=1 and redirect_pc_out=latched target; head ignored; then IDLE.
  - The ROB, RS, LSB and Regfile tags clear on this pulse. The Regfile write issued on the previous edge has already landed, so there is no write/clear collision.
- HALTED: halt_out=1 sticky; no further pops or commits until reset.
- commit_cnt_out increments by 1 at every rob_pop_out assertion edge and wraps modulo 2^32.
- At most one of {Regfile write, LSB release} is issued per cycle.
- rd=0 writes are forwarded unchanged; the Regfile discards them.

Decomposition:
- config.vh (shared) holds: WordWidth, RegIdxWidth, ROBIdxWidth, InstrIdWidth, ZERO, instruction-id constants.
- FSM state encodings are local localparams.
- No sub-module: single always block for the FSM plus the counter.

Test Plan:
- Reset/idle: rst_n_in low then high, ROB empty -> all outputs 0, state IDLE, commit_cnt_out=0.
- ALU commit: head pos=3, rd=5, res=0xDEADBEEF, has_rd=1 -> next edge: en=1, rd=5, rob_pos=3, res=0xDEADBEEF and rob_pop=1 for one cycle; the following cycle the head is ignored; commit_cnt_out=1.
- Store: head pos=7 is_store -> commit_to_lsb_en=1 with pos=7, no pop. LSB done with pos=6 -> no pop; done with pos=7 -> rob_pop=1, back to IDLE.
- Mispredict JALR: rd=1, res=0x104, target=0x200 -> edge 1: regfile write (rd=1, res=0x104) + pop; edge 2: clear_branch_out=1, redirect_en_out=1, redirect_pc_out=0x200; edge 3: both 0.
- rdy_in stall: drop rdy_in for 3 cycles right after a Regfile pulse -> pulse held and counter unchanged; released 1 cycle after rdy_in returns; no double commit.
- Async reset mid-WAIT_STORE and halt:
  - rst_n_in low between clock edges -> outputs 0 immediately, IDLE.
  - halt head -> pop, halt_out=1; later ready heads produce no pops.

Source files
------------

// File: rtl/commit_ctrl_pkg.sv
// Shared widths and FSM state type for the in-order commit sequencer.
// Imported by the commit interface and by the commit_ctrl top.
package commit_ctrl_pkg;

  localparam int ROB_IDX_W_DEF  = 4;
  localparam int INSTR_ID_W_DEF = 6;
  localparam int WORD_W_DEF     = 32;
  localparam int REG_IDX_W      = 5;
  localparam int CNT_W          = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_STORE,
    ST_FLUSH,
    ST_HALTED
  } commit_state_e;

endpackage

// File: rtl/commit_ctrl_if.sv
// Bundle between the ROB head / LSB ack on one side and the commit sequencer on the other.
// master = commit sequencer, slave = ROB/LSB/Regfile/fetch environment.
interface commit_ctrl_if
  import commit_ctrl_pkg::*;
#(
  parameter int ROB_IDX_W  = ROB_IDX_W_DEF,
  parameter int INSTR_ID_W = INSTR_ID_W_DEF,
  parameter int WORD_W     = WORD_W_DEF
);

  logic                  rob_head_valid_in;
  logic                  rob_head_ready_in;
  logic [ROB_IDX_W-1:0]  rob_head_pos_in;
  logic [INSTR_ID_W-1:0] rob_head_instr_id_in;
  logic                  rob_head_has_rd_in;
  logic [REG_IDX_W-1:0]  rob_head_rd_in;
  logic [WORD_W-1:0]     rob_head_res_in;
  logic                  rob_head_is_store_in;
  logic                  rob_head_mispred_in;
  logic [WORD_W-1:0]     rob_head_target_in;
  logic                  rob_head_is_halt_in;
  logic                  lsb_store_done_in;
  logic [ROB_IDX_W-1:0]  lsb_store_pos_in;

  logic                  rob_pop_out;
  logic                  commit_to_regfile_en_out;
  logic [INSTR_ID_W-1:0] commit_to_regfile_instr_id_out;
  logic [REG_IDX_W-1:0]  commit_to_regfile_rd_out;
  logic [ROB_IDX_W-1:0]  commit_to_regfile_rob_pos_out;
  logic [WORD_W-1:0]     commit_to_regfile_res_out;
  logic                  commit_to_lsb_en_out;
  logic [ROB_IDX_W-1:0]  commit_to_lsb_rob_pos_out;
  logic                  clear_branch_out;
  logic                  redirect_en_out;
  logic [WORD_W-1:0]     redirect_pc_out;
  logic                  halt_out;
  logic [CNT_W-1:0]      commit_cnt_out;

  modport master (
    input  rob_head_valid_in, rob_head_ready_in, rob_head_pos_in, rob_head_instr_id_in,
           rob_head_has_rd_in, rob_head_rd_in, rob_head_res_in, rob_head_is_store_in,
           rob_head_mispred_in, rob_head_target_in, rob_head_is_halt_in,
           lsb_store_done_in, lsb_store_pos_in,
    output rob_pop_out, commit_to_regfile_en_out, commit_to_regfile_instr_id_out,
           commit_to_regfile_rd_out, commit_to_regfile_rob_pos_out, commit_to_regfile_res_out,
           commit_to_lsb_en_out, commit_to_lsb_rob_pos_out, clear_branch_out,
           redirect_en_out, redirect_pc_out, halt_out, commit_cnt_out
  );

  modport slave (
    output rob_head_valid_in, rob_head_ready_in, rob_head_pos_in, rob_head_instr_id_in,
           rob_head_has_rd_in, rob_head_rd_in, rob_head_res_in, rob_head_is_store_in,
           rob_head_mispred_in, rob_head_target_in, rob_head_is_halt_in,
           lsb_store_done_in, lsb_store_pos_in,
    input  rob_pop_out, commit_to_regfile_en_out, commit_to_regfile_instr_id_out,
           commit_to_regfile_rd_out, commit_to_regfile_rob_pos_out, commit_to_regfile_res_out,
           commit_to_lsb_en_out, commit_to_lsb_rob_pos_out, clear_branch_out,
           redirect_en_out, redirect_pc_out, halt_out, commit_cnt_out
  );

endinterface

// File: rtl/commit_ctrl.sv
// In-order retirement sequencer: retires the ROB head, releases stores to the LSB,
// turns a mispredict into a one-cycle flush/redirect and latches halt.
module commit_ctrl
  import commit_ctrl_pkg::*;
#(
  parameter int ROB_IDX_W  = ROB_IDX_W_DEF,
  parameter int INSTR_ID_W = INSTR_ID_W_DEF,
  parameter int WORD_W     = WORD_W_DEF
) (
  input  logic          clk_in,
  input  logic          rst_n_in,
  input  logic          rdy_in,
  commit_ctrl_if.master bus
);

  commit_state_e         state_q, state_d;
  logic [ROB_IDX_W-1:0]  store_pos_q, store_pos_d;
  logic [WORD_W-1:0]     target_q, target_d;

  logic                  pop_q, pop_d;
  logic                  rf_en_q, rf_en_d;
  logic [INSTR_ID_W-1:0] rf_id_q, rf_id_d;
  logic [REG_IDX_W-1:0]  rf_rd_q, rf_rd_d;
  logic [ROB_IDX_W-1:0]  rf_pos_q, rf_pos_d;
  logic [WORD_W-1:0]     rf_res_q, rf_res_d;
  logic                  lsb_en_q, lsb_en_d;
  logic [ROB_IDX_W-1:0]  lsb_pos_q, lsb_pos_d;
  logic                  clear_q, clear_d;
  logic                  redir_q, redir_d;
  logic [WORD_W-1:0]     redir_pc_q, redir_pc_d;
  logic                  halt_q, halt_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic                  head_live;
  logic                  store_match;

  // The ROB only advances its head on the edge after a pop, so that cycle's head is stale.
  assign head_live   = ~pop_q & bus.rob_head_valid_in & bus.rob_head_ready_in;
  assign store_match = bus.lsb_store_done_in & (bus.lsb_store_pos_in == store_pos_q);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= ST_IDLE;
      store_pos_q <= '0;
      target_q    <= '0;
      pop_q       <= 1'b0;
      rf_en_q     <= 1'b0;
      rf_id_q     <= '0;
      rf_rd_q     <= '0;
      rf_pos_q    <= '0;
      rf_res_q    <= '0;
      lsb_en_q    <= 1'b0;
      lsb_pos_q   <= '0;
      clear_q     <= 1'b0;
      redir_q     <= 1'b0;
      redir_pc_q  <= '0;
      halt_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      store_pos_q <= store_pos_d;
      target_q    <= target_d;
      pop_q       <= pop_d;
      rf_en_q     <= rf_en_d;
      rf_id_q     <= rf_id_d;
      rf_rd_q     <= rf_rd_d;
      rf_pos_q    <= rf_pos_d;
      rf_res_q    <= rf_res_d;
      lsb_en_q    <= lsb_en_d;
      lsb_pos_q   <= lsb_pos_d;
      clear_q     <= clear_d;
      redir_q     <= redir_d;
      redir_pc_q  <= redir_pc_d;
      halt_q      <= halt_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    store_pos_d = store_pos_q;
    target_d    = target_q;
    pop_d       = pop_q;
    rf_en_d     = rf_en_q;
    rf_id_d     = rf_id_q;
    rf_rd_d     = rf_rd_q;
    rf_pos_d    = rf_pos_q;
    rf_res_d    = rf_res_q;
    lsb_en_d    = lsb_en_q;
    lsb_pos_d   = lsb_pos_q;
    clear_d     = clear_q;
    redir_d     = redir_q;
    redir_pc_d  = redir_pc_q;
    halt_d      = halt_q;
    cnt_d       = cnt_q;

    // With rdy_in low everything, including pending pulses, is frozen.
    if (rdy_in) begin
      pop_d    = 1'b0;
      rf_en_d  = 1'b0;
      lsb_en_d = 1'b0;
      clear_d  = 1'b0;
      redir_d  = 1'b0;

      unique case (state_q)
        ST_IDLE: begin
          if (head_live) begin
            if (bus.rob_head_is_halt_in) begin
              pop_d   = 1'b1;
              halt_d  = 1'b1;
              state_d = ST_HALTED;
            end else if (bus.rob_head_is_store_in) begin
              lsb_en_d    = 1'b1;
              lsb_pos_d   = bus.rob_head_pos_in;
              store_pos_d = bus.rob_head_pos_in;
              state_d     = ST_WAIT_STORE;
            end else begin
              pop_d = 1'b1;
              if (bus.rob_head_has_rd_in) begin
                rf_en_d  = 1'b1;
                rf_id_d  = bus.rob_head_instr_id_in;
                rf_rd_d  = bus.rob_head_rd_in;
                rf_pos_d = bus.rob_head_pos_in;
                rf_res_d = bus.rob_head_res_in;
              end
              if (bus.rob_head_mispred_in) begin
                target_d = bus.rob_head_target_in;
                state_d  = ST_FLUSH;
              end
            end
          end
        end
        ST_WAIT_STORE: begin
          if (store_match) begin
            pop_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_FLUSH: begin
          clear_d    = 1'b1;
          redir_d    = 1'b1;
          redir_pc_d = target_q;
          state_d    = ST_IDLE;
        end
        ST_HALTED: begin
          halt_d = 1'b1;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase

      if (pop_d) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.rob_pop_out                    = pop_q;
  assign bus.commit_to_regfile_en_out       = rf_en_q;
  assign bus.commit_to_regfile_instr_id_out = rf_id_q;
  assign bus.commit_to_regfile_rd_out       = rf_rd_q;
  assign bus.commit_to_regfile_rob_pos_out  = rf_pos_q;
  assign bus.commit_to_regfile_res_out      = rf_res_q;
  assign bus.commit_to_lsb_en_out           = lsb_en_q;
  assign bus.commit_to_lsb_rob_pos_out      = lsb_pos_q;
  assign bus.clear_branch_out               = clear_q;
  assign bus.redirect_en_out                = redir_q;
  assign bus.redirect_pc_out                = redir_pc_q;
  assign bus.halt_out                       = halt_q;
  assign bus.commit_cnt_out                 = cnt_q;

endmodule

// File: tb/tb_commit_ctrl.sv
// Bench for commit_ctrl: directed vector table, hand-written multi-cycle corners,
// then a randomized ROB/LSB environment checked against an event-level model.
module tb_commit_ctrl;

  typedef struct packed {
    logic [3:0]  pos;
    logic [5:0]  id;
    logic        has_rd;
    logic [4:0]  rd;
    logic [31:0] res;
    logic        is_store;
    logic        mispred;
    logic [31:0] target;
    logic        is_halt;
  } rob_entry_t;

  typedef struct packed {
    logic        pop;
    logic        rf_en;
    logic [5:0]  id;
    logic [4:0]  rd;
    logic [3:0]  rf_pos;
    logic [31:0] res;
    logic        lsb_en;
    logic [3:0]  lsb_pos;
    logic        flush;
    logic [31:0] pc;
    logic        halt;
    logic [31:0] cnt;
  } exp_t;

  typedef struct {
    logic       rdy;
    logic       valid;
    logic       ready;
    rob_entry_t e;
    logic       done;
    logic [3:0] done_pos;
    exp_t       x;
  } vec_t;

  logic clk_in = 1'b0;
  logic rst_n_in = 1'b0;
  logic rdy_in = 1'b1;
  int   total = 0;
  int   bad = 0;

  commit_ctrl_if #(.ROB_IDX_W(4), .INSTR_ID_W(6), .WORD_W(32)) bus ();

  commit_ctrl #(.ROB_IDX_W(4), .INSTR_ID_W(6), .WORD_W(32)) dut (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .rdy_in   (rdy_in),
    .bus      (bus)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic rob_entry_t ent(input logic [3:0] pos, input logic [5:0] id, input logic has_rd,
                                     input logic [4:0] rd, input logic [31:0] res, input logic st,
                                     input logic mp, input logic [31:0] tgt, input logic hl);
    rob_entry_t e;
    e.pos = pos; e.id = id; e.has_rd = has_rd; e.rd = rd; e.res = res;
    e.is_store = st; e.mispred = mp; e.target = tgt; e.is_halt = hl;
    return e;
  endfunction

  function automatic exp_t ex(input logic pop, input logic rf, input logic [5:0] id, input logic [4:0] rd,
                              input logic [3:0] rf_pos, input logic [31:0] res, input logic lsb,
                              input logic [3:0] lpos, input logic fl, input logic [31:0] pc,
                              input logic halt, input logic [31:0] cnt);
    exp_t x;
    x.pop = pop; x.rf_en = rf; x.id = id; x.rd = rd; x.rf_pos = rf_pos; x.res = res;
    x.lsb_en = lsb; x.lsb_pos = lpos; x.flush = fl; x.pc = pc; x.halt = halt; x.cnt = cnt;
    return x;
  endfunction

  function automatic vec_t row(input logic rdy, input logic valid, input logic ready, input rob_entry_t e,
                               input logic done, input logic [3:0] dpos, input exp_t x);
    vec_t v;
    v.rdy = rdy; v.valid = valid; v.ready = ready; v.e = e; v.done = done; v.done_pos = dpos; v.x = x;
    return v;
  endfunction

  function automatic logic [127:0] allOut();
    return {7'd0, bus.rob_pop_out, bus.commit_to_regfile_en_out, bus.commit_to_regfile_instr_id_out,
            bus.commit_to_regfile_rd_out, bus.commit_to_regfile_rob_pos_out, bus.commit_to_regfile_res_out,
            bus.commit_to_lsb_en_out, bus.commit_to_lsb_rob_pos_out, bus.clear_branch_out,
            bus.redirect_en_out, bus.redirect_pc_out, bus.halt_out, bus.commit_cnt_out};
  endfunction

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic applyStimulus(input logic rdy, input logic valid, input logic ready, input rob_entry_t e,
                               input logic done, input logic [3:0] dpos);
    rdy_in                   = rdy;
    bus.rob_head_valid_in    = valid;
    bus.rob_head_ready_in    = ready;
    bus.rob_head_pos_in      = e.pos;
    bus.rob_head_instr_id_in = e.id;
    bus.rob_head_has_rd_in   = e.has_rd;
    bus.rob_head_rd_in       = e.rd;
    bus.rob_head_res_in      = e.res;
    bus.rob_head_is_store_in = e.is_store;
    bus.rob_head_mispred_in  = e.mispred;
    bus.rob_head_target_in   = e.target;
    bus.rob_head_is_halt_in  = e.is_halt;
    bus.lsb_store_done_in    = done;
    bus.lsb_store_pos_in     = dpos;
  endtask

  task automatic checkExp(input string tag, input exp_t x);
    checkOutput({tag, ".pop"},   bus.rob_pop_out, x.pop);
    checkOutput({tag, ".rf_en"}, bus.commit_to_regfile_en_out, x.rf_en);
    checkOutput({tag, ".lsb"},   bus.commit_to_lsb_en_out, x.lsb_en);
    checkOutput({tag, ".clear"}, bus.clear_branch_out, x.flush);
    checkOutput({tag, ".redir"}, bus.redirect_en_out, x.flush);
    checkOutput({tag, ".halt"},  bus.halt_out, x.halt);
    checkOutput({tag, ".cnt"},   bus.commit_cnt_out, x.cnt);
    if (x.rf_en) begin
      checkOutput({tag, ".rf_bundle"},
                  {bus.commit_to_regfile_instr_id_out, bus.commit_to_regfile_rd_out,
                   bus.commit_to_regfile_rob_pos_out, bus.commit_to_regfile_res_out},
                  {x.id, x.rd, x.rf_pos, x.res});
    end
    if (x.lsb_en) checkOutput({tag, ".lsb_pos"}, bus.commit_to_lsb_rob_pos_out, x.lsb_pos);
    if (x.flush)  checkOutput({tag, ".redir_pc"}, bus.redirect_pc_out, x.pc);
  endtask

  task automatic resetDut();
    rob_entry_t z;
    z = ent(0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, z, 1'b0, 4'd0);
    rst_n_in = 1'b0;
    repeat (2) @(posedge clk_in);
    #3;
    rst_n_in = 1'b1;
    tick();
    checkOutput("reset_idle", allOut(), 128'd0);
  endtask

  // Randomized environment: a ROB queue feeding the head, an LSB that acks stores late.
  rob_entry_t rob_q[$];
  logic [3:0] next_pos = 4'd1;

  function automatic rob_entry_t randEntry();
    rob_entry_t e;
    e.pos      = next_pos;
    next_pos   = (next_pos == 4'd15) ? 4'd1 : next_pos + 4'd1;
    e.id       = 6'($urandom);
    e.rd       = 5'($urandom);
    e.res      = $urandom;
    e.target   = $urandom;
    e.is_store = ($urandom_range(0, 4) == 0);
    e.mispred  = !e.is_store && ($urandom_range(0, 6) == 0);
    e.has_rd   = !e.is_store && ($urandom_range(0, 3) != 0);
    e.is_halt  = 1'b0;
    return e;
  endfunction

  vec_t vecs[$];

  initial begin
    rob_entry_t alu3, st7, jalr, wp, z0, none, e;
    logic [127:0] snap;
    exp_t x;
    logic m_halted, m_store_wait, m_flush_due, m_just_popped;
    logic [3:0] m_wait_pos;
    logic [31:0] m_target, m_cnt;
    logic r_rdy, r_valid, r_ready, r_done;
    logic [3:0] r_dpos;
    logic e_pop, e_rf, e_lsb, e_fl;

    none = ent(0, 0, 0, 0, 0, 0, 0, 0, 0);
    alu3 = ent(3, 1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0);
    st7  = ent(7, 2, 0, 0, 0, 1, 0, 0, 0);
    jalr = ent(8, 3, 1, 1, 32'h104, 0, 1, 32'h200, 0);
    wp   = ent(9, 4, 1, 2, 32'h999, 0, 0, 0, 0);
    z0   = ent(10, 5, 1, 0, 32'h55, 0, 0, 0, 0);

    vecs.push_back(row(1, 0, 0, none, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(row(1, 1, 1, alu3, 0, 0, ex(1, 1, 1, 5, 3, 32'hDEADBEEF, 0, 0, 0, 0, 0, 1)));
    vecs.push_back(row(1, 1, 1, alu3, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)));
    vecs.push_back(row(1, 1, 1, st7,  0, 0, ex(0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0, 1)));
    vecs.push_back(row(1, 1, 1, st7,  1, 6, ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)));
    vecs.push_back(row(1, 1, 1, st7,  1, 7, ex(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2)));
    vecs.push_back(row(1, 1, 1, jalr, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2)));
    vecs.push_back(row(1, 1, 1, jalr, 0, 0, ex(1, 1, 3, 1, 8, 32'h104, 0, 0, 0, 0, 0, 3)));
    vecs.push_back(row(1, 1, 1, wp,   0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h200, 0, 3)));
    vecs.push_back(row(1, 0, 0, none, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3)));
    vecs.push_back(row(1, 1, 1, z0,   0, 0, ex(1, 1, 5, 0, 10, 32'h55, 0, 0, 0, 0, 0, 4)));
    vecs.push_back(row(1, 0, 0, none, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4)));

    resetDut();

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rdy, vecs[i].valid, vecs[i].ready, vecs[i].e, vecs[i].done, vecs[i].done_pos);
      tick();
      checkExp($sformatf("vec%0d", i), vecs[i].x);
    end

    // rdy_in stall right after a Regfile pulse: pulse and count held, no second commit.
    e = ent(11, 9, 1, 7, 32'h1234, 0, 0, 0, 0);
    applyStimulus(1, 1, 1, e, 0, 0);
    tick();
    checkExp("stall_commit", ex(1, 1, 9, 7, 11, 32'h1234, 0, 0, 0, 0, 0, 5));
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 1, 1, e, 0, 0);
      tick();
      checkExp($sformatf("stall_hold%0d", k), ex(1, 1, 9, 7, 11, 32'h1234, 0, 0, 0, 0, 0, 5));
    end
    applyStimulus(1, 1, 1, e, 0, 0);
    tick();
    checkExp("stall_release", ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5));

    // Asynchronous reset between edges while a store is outstanding.
    e = ent(12, 10, 0, 0, 0, 1, 0, 0, 0);
    applyStimulus(1, 1, 1, e, 0, 0);
    tick();
    checkExp("store_release", ex(0, 0, 0, 0, 0, 0, 1, 12, 0, 0, 0, 5));
    #2;
    rst_n_in = 1'b0;
    #1;
    checkOutput("async_reset_outputs", allOut(), 128'd0);
    #2;
    rst_n_in = 1'b1;
    e = ent(1, 11, 1, 3, 32'hABC, 0, 0, 0, 0);
    applyStimulus(1, 1, 1, e, 0, 0);
    tick();
    checkExp("post_reset_idle", ex(1, 1, 11, 3, 1, 32'hABC, 0, 0, 0, 0, 0, 1));
    applyStimulus(1, 0, 0, none, 0, 0);
    tick();

    // Halt: one pop, then sticky halt with no further retirement.
    e = ent(2, 12, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(1, 1, 1, e, 0, 0);
    tick();
    checkExp("halt_pop", ex(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2));
    for (int k = 0; k < 4; k++) begin
      e = ent(4'(3 + k), 6'(13 + k), 1, 4, 32'h77, 4'(k) == 4'd2, 0, 0, 0);
      applyStimulus(1, 1, 1, e, 1, 4'(3 + k));
      tick();
      checkExp($sformatf("halted%0d", k), ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2));
    end

    // Randomized run against the event-level model.
    resetDut();
    m_halted = 0; m_store_wait = 0; m_flush_due = 0; m_just_popped = 0;
    m_wait_pos = 0; m_target = 0; m_cnt = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      while (rob_q.size() < 4 && $urandom_range(0, 3) != 0) rob_q.push_back(randEntry());
      r_rdy   = ($urandom_range(0, 7) != 0);
      r_valid = (rob_q.size() > 0);
      r_ready = ($urandom_range(0, 3) != 0);
      e       = r_valid ? rob_q[0] : randEntry();
      r_done  = 1'b0;
      r_dpos  = 4'($urandom);
      if (m_store_wait && r_rdy && $urandom_range(0, 2) == 0) begin
        r_done = 1'b1;
        r_dpos = ($urandom_range(0, 3) == 0) ? m_wait_pos + 4'd1 : m_wait_pos;
      end else if ($urandom_range(0, 9) == 0) begin
        r_done = 1'b1;
      end
      applyStimulus(r_rdy, r_valid, r_ready, e, r_done, r_dpos);
      snap = allOut();

      e_pop = 0; e_rf = 0; e_lsb = 0; e_fl = 0;
      if (r_rdy) begin
        if (m_halted) begin
        end else if (m_flush_due) begin
          e_fl = 1;
        end else if (m_just_popped) begin
        end else if (m_store_wait) begin
          e_pop = r_done && (r_dpos == m_wait_pos);
        end else if (r_valid && r_ready) begin
          if (e.is_halt) e_pop = 1;
          else if (e.is_store) e_lsb = 1;
          else begin
            e_pop = 1;
            e_rf  = e.has_rd;
          end
        end
      end

      tick();

      if (!r_rdy) begin
        checkOutput("rnd_hold", allOut(), snap);
      end else begin
        x = ex(e_pop, e_rf, e.id, e.rd, e.pos, e.res, e_lsb, e.pos, e_fl, m_target,
               m_halted, m_cnt + (e_pop ? 32'd1 : 32'd0));
        checkExp("rnd", x);
        if (e_pop) begin
          m_cnt = m_cnt + 32'd1;
          if (m_store_wait) m_store_wait = 0;
          else if (e.is_halt) m_halted = 1;
          else if (e.mispred) begin
            m_flush_due = 1;
            m_target    = e.target;
          end
          void'(rob_q.pop_front());
        end
        if (e_lsb) begin
          m_store_wait = 1;
          m_wait_pos   = e.pos;
        end
        if (e_fl) begin
          m_flush_due = 0;
          rob_q.delete();
        end
        m_just_popped = e_pop;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
